// File: rtl/uart_rx_fifo_if.sv
// Bundle of the UART receive-FIFO data path: the receiver's write side,
// the consumer's read side and the status/overflow signals.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    Rx_Data;
    logic          Rx_DV;
    logic [7:0]    Dout;
    logic          Dout_Valid;
    logic          Dout_Ready;
    logic [CW-1:0] Count;
    logic          Full;
    logic          Almost_Full;
    logic          Overflow;
    logic          Overflow_Clr;
    logic [7:0]    Drop_Count;

    // Side that feeds the receiver bytes and consumes the queue
    modport master (
        output Rx_Data, Rx_DV, Dout_Ready, Overflow_Clr,
        input  Dout, Dout_Valid, Count, Full, Almost_Full, Overflow, Drop_Count
    );

    // The FIFO itself
    modport slave (
        input  Rx_Data, Rx_DV, Dout_Ready, Overflow_Clr,
        output Dout, Dout_Valid, Count, Full, Almost_Full, Overflow, Drop_Count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver. Rx_DV is registered into a
// write-pending bit because the byte arrives one cycle after the pulse.
// First-word-fall-through read; writes into a full queue are dropped and
// counted unless a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Byte storage; deliberately never reset
    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          wr_pend_reg;
    logic          overflow_reg;
    logic [7:0]    drop_count_reg;

    logic          full;
    logic          valid;
    logic          pop;
    logic          wr_accept;
    logic          drop;

    // Status is derived from the registered occupancy only
    assign full  = (count_reg == CW'(DEPTH));
    assign valid = (count_reg != '0);

    // A pop needs a presented head byte; a full queue still accepts a
    // write when the same edge pops, so nothing is lost in that case
    assign pop       = valid && bus.Dout_Ready;
    assign wr_accept = wr_pend_reg && (!full || pop);
    assign drop      = wr_pend_reg && full && !pop;

    assign bus.Dout        = mem[rd_ptr_reg];
    assign bus.Dout_Valid  = valid;
    assign bus.Count       = count_reg;
    assign bus.Full        = full;
    assign bus.Almost_Full = (count_reg >= CW'(AF_LEVEL));
    assign bus.Overflow    = overflow_reg;
    assign bus.Drop_Count  = drop_count_reg;

    // Occupancy moves only when exactly one of write/pop happens
    always_comb begin
        count_next = count_reg;
        if (wr_accept && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !wr_accept) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Pointers, occupancy and the delayed write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            wr_pend_reg <= 1'b0;
        end else begin
            wr_pend_reg <= bus.Rx_DV;
            count_reg   <= count_next;
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    // Storage write; asynchronous read keeps the head byte visible at once
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= bus.Rx_Data;
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (bus.Overflow_Clr) begin
                drop_count_reg <= 8'd1;
            end else if (drop_count_reg != 8'hFF) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end
        end else if (bus.Overflow_Clr) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of byte entries; power of two, 4..256.
REQ-002 Parameter: AF_LEVEL, 12, Almost_Full threshold in entries; 1..DEPTH.
REQ-003 Port: clk  input  1  single clock for all logic; rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: Rx_Data  input  8  received byte from the UART receiver.
REQ-006 Port: Rx_DV  input  1  one-cycle receive-complete pulse from the UART receiver.
REQ-007 Port: Dout  output  8  head-of-queue byte; meaningful only while Dout_Valid=1.
REQ-008 Port: Dout_Valid  output  1  queue non-empty; head byte presented.
REQ-009 Port: Dout_Ready  input  1  consumer accepts head byte.
REQ-010 Port: Count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 Port: Full  output  1  Count==DEPTH.
REQ-012 Port: Almost_Full  output  1  Count>=AF_LEVEL.
REQ-013 Port: Overflow  output  1  sticky flag: at least one byte dropped.
REQ-014 Port: Overflow_Clr  input  1  synchronous clear of Overflow and Drop_Count.
REQ-015 Port: Drop_Count  output  8  number of dropped bytes, saturating at 255.

Function
REQ-016 Rx_Data becomes valid one cycle after the Rx_DV pulse; the block SHALL register Rx_DV into a write-pending bit and SHALL write Rx_Data on the cycle that bit is 1 (write strobe = Rx_DV delayed by one clk).
REQ-017 Storage SHALL be a DEPTH-entry circular buffer with read and write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 Read is first-word-fall-through: Dout SHALL equal the entry at the read pointer whenever Dout_Valid=1, with Dout_Valid = (Count!=0).
REQ-019 Pop SHALL occur on a rising edge where Dout_Valid=1 and Dout_Ready=1; Dout_Ready while Dout_Valid=0 SHALL be ignored.
REQ-020 Write to a non-full queue SHALL store the byte, advance the write pointer and increment Count, unless a pop occurs in the same cycle.
REQ-021 Simultaneous write and pop SHALL leave Count unchanged and advance both pointers; this SHALL apply when Full=1 (the byte is accepted, no drop).
REQ-022 Write while Full=1 without a simultaneous pop SHALL discard the byte, leave pointers, Count and stored data unchanged, set Overflow and increment Drop_Count (saturating at 255).
REQ-023 Write when Count==0 SHALL raise Dout_Valid on the following cycle with Dout equal to that byte; same-cycle Dout_Ready has no effect.
REQ-024 Overflow_Clr SHALL zero Overflow and Drop_Count on the next edge; a drop in the same cycle SHALL win (Overflow=1, Drop_Count=1).
REQ-025 Full, Almost_Full, Dout_Valid and Count SHALL be registered or derived from registered state only; no combinational path from Dout_Ready or Rx_DV to any output.
REQ-026 Stored data contents SHALL NOT be reset; only pointers, Count, flags and counters are reset.

Reset
REQ-027 While rst_n=0: read/write pointers=0, Count=0, write-pending=0, Dout_Valid=0, Full=0, Almost_Full=0, Overflow=0, Drop_Count=0.
REQ-028 Reset asserted mid-operation SHALL empty the queue immediately and cancel any pending write; an Rx_DV pulse in the cycle before deassertion SHALL be lost.
REQ-029 After rst_n rises, the first Rx_DV pulse SHALL be accepted normally.

Verification
REQ-030 Rx_DV pulse with Rx_Data=0x55 presented one cycle later, Dout_Ready=0 -> two cycles after pulse Dout_Valid=1, Dout=0x55, Count=1.
REQ-031 Write 0x00..0x0F (DEPTH=16) with Dout_Ready=0 -> Almost_Full=1 after 12th, Full=1 after 16th; then read all 16 -> bytes in order 0x00..0x0F, Empty at end, pointers wrapped to 0.
REQ-032 Full queue, three further writes, no pops -> Overflow=1, Drop_Count=3, Count=16, head still 0x00; assert Overflow_Clr -> both zero next cycle.
REQ-033 Full queue, write 0xA5 coincident with pop (Dout_Ready=1) -> Count stays 16, no Overflow, 0xA5 emerges as 16th subsequent read.
REQ-034 Queue holding 5 bytes, rst_n pulsed low mid-stream with a pending write -> Count=0, Dout_Valid=0, Overflow=0 immediately; next Rx_DV with 0x3C -> Dout=0x3C.
